// File: rtl/led_ctrl_pkg.sv
// Shared constants and types for the RGB LED scheduler: mode codes, button indices,
// brightness/ramp/PWM constants and the debouncer state encoding.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // DB_IDLE waits for a stable release; DB_ARMED waits for a stable press.
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_ARMED = 1'b1
  } db_state_e;

  localparam int BTN_NEXT  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  localparam int         NUM_LEDS     = 4;
  localparam int         PWM_W        = 8;
  localparam logic [3:0] BRIGHT_RESET = 4'd8;
  localparam logic [7:0] RAMP_STEP    = 8'd16;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:     return MODE_SOLID;
      MODE_SOLID:   return MODE_CHASE;
      MODE_CHASE:   return MODE_BREATHE;
      default:      return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer then a debouncer that emits one pulse per
// press, only after the input has first been seen stably released.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int P_DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (P_DEBOUNCE_CYCLES > 1) ? $clog2(P_DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          level;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_d;

  assign level = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  // The counter only runs while the level matches what the current state waits for;
  // any bounce back restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (level == (state_q == DB_ARMED)) begin
      if (cnt_q == CW'(P_DEBOUNCE_CYCLES - 1)) begin
        state_d = (state_q == DB_ARMED) ? DB_IDLE : DB_ARMED;
        pulse_d = (state_q == DB_ARMED);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_led_scheduler.sv
// Four-LED RGB animation controller: mode FSM, brightness, step timer, chase/breathe
// sequencing and registered 8-bit PWM on all twelve channels.
module rgb_led_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int P_STEP_CYCLES     = 10_000_000,
  parameter int P_DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       I_CLK_100MHZ,
  input  logic       I_RST,
  input  logic [3:0] I_SW,
  input  logic [3:0] I_BTN,
  output logic [3:0] O_LED,
  output logic [3:0] O_LED_R,
  output logic [3:0] O_LED_G,
  output logic [3:0] O_LED_B
);

  localparam int STEP_W = (P_STEP_CYCLES > 1) ? $clog2(P_STEP_CYCLES) : 1;

  logic [3:0]        btn_pulse;
  mode_e             mode_q, mode_d;
  logic              mode_chg;
  logic              paused_q;
  logic [3:0]        bright_q;
  logic [STEP_W-1:0] step_cnt_q;
  logic              step_tick;
  logic              hb_q;
  logic [1:0]        pos_q, col_q;
  logic [7:0]        ramp_q;
  logic              ramp_down_q;
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic [11:0]       breathe_prod;
  logic [PWM_W-1:0]  base_duty, breathe_duty;
  logic [PWM_W-1:0]  duty_r [NUM_LEDS];
  logic [PWM_W-1:0]  duty_g [NUM_LEDS];
  logic [PWM_W-1:0]  duty_b [NUM_LEDS];
  logic [3:0]        r_on, g_on, b_on;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)) u_db (
      .clk  (I_CLK_100MHZ),
      .rst  (I_RST),
      .btn  (I_BTN[i]),
      .pulse(btn_pulse[i])
    );
  end

  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) mode_q <= MODE_OFF;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d   = mode_q;
    mode_chg = 1'b0;
    if (btn_pulse[BTN_NEXT]) begin
      mode_d   = next_mode(mode_q);
      mode_chg = 1'b1;
    end
  end

  assign step_tick = !paused_q && (step_cnt_q == STEP_W'(P_STEP_CYCLES - 1));

  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      paused_q    <= 1'b0;
      bright_q    <= BRIGHT_RESET;
      step_cnt_q  <= '0;
      hb_q        <= 1'b0;
      pos_q       <= 2'd0;
      col_q       <= 2'd0;
      ramp_q      <= 8'd0;
      ramp_down_q <= 1'b0;
    end else begin
      if (btn_pulse[BTN_PAUSE]) paused_q <= ~paused_q;

      case ({btn_pulse[BTN_UP], btn_pulse[BTN_DOWN]})
        2'b10:   if (bright_q != 4'd15) bright_q <= bright_q + 4'd1;
        2'b01:   if (bright_q != 4'd0)  bright_q <= bright_q - 4'd1;
        default: ;
      endcase

      // A mode change restarts the animation from its first frame.
      if (mode_chg) begin
        step_cnt_q  <= '0;
        pos_q       <= 2'd0;
        col_q       <= 2'd0;
        ramp_q      <= 8'd0;
        ramp_down_q <= 1'b0;
      end else if (step_tick) begin
        step_cnt_q <= '0;
        hb_q       <= ~hb_q;
        pos_q      <= pos_q + 2'd1;
        if (pos_q == 2'd3) col_q <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        if (!ramp_down_q) begin
          if (ramp_q > (8'hFF - RAMP_STEP)) begin
            ramp_q      <= 8'hFF;
            ramp_down_q <= 1'b1;
          end else begin
            ramp_q <= ramp_q + RAMP_STEP;
          end
        end else begin
          if (ramp_q < RAMP_STEP) begin
            ramp_q      <= 8'd0;
            ramp_down_q <= 1'b0;
          end else begin
            ramp_q <= ramp_q - RAMP_STEP;
          end
        end
      end else if (!paused_q) begin
        step_cnt_q <= step_cnt_q + STEP_W'(1);
      end
    end
  end

  assign base_duty    = {bright_q, bright_q};
  assign breathe_prod = {4'b0, ramp_q} * {8'b0, bright_q};
  assign breathe_duty = breathe_prod[11:4];

  always_comb begin
    for (int n = 0; n < NUM_LEDS; n++) begin
      duty_r[n] = '0;
      duty_g[n] = '0;
      duty_b[n] = '0;
      case (mode_q)
        MODE_SOLID: begin
          duty_r[n] = base_duty;
          duty_g[n] = base_duty;
          duty_b[n] = base_duty;
        end
        MODE_CHASE: begin
          if (pos_q == 2'(n)) begin
            if (col_q == 2'd0) duty_r[n] = base_duty;
            if (col_q == 2'd1) duty_g[n] = base_duty;
            if (col_q == 2'd2) duty_b[n] = base_duty;
          end
        end
        MODE_BREATHE: begin
          duty_r[n] = breathe_duty;
          duty_g[n] = breathe_duty;
          duty_b[n] = breathe_duty;
        end
        default: ;
      endcase
      r_on[n] = I_SW[n] && (pwm_cnt_q < duty_r[n]);
      g_on[n] = I_SW[n] && (pwm_cnt_q < duty_g[n]);
      b_on[n] = I_SW[n] && (pwm_cnt_q < duty_b[n]);
    end
  end

  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      pwm_cnt_q <= '0;
      O_LED     <= 4'd0;
      O_LED_R   <= 4'd0;
      O_LED_G   <= 4'd0;
      O_LED_B   <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      O_LED     <= {hb_q, paused_q, mode_q};
      O_LED_R   <= r_on;
      O_LED_G   <= g_on;
      O_LED_B   <= b_on;
    end
  end

endmodule
